tt_um_8_pc_sequencer: RTL and testbench
=======================================

TT_UM_8_PC_SEQUENCER -- requirements
Module: tt_um_8_pc_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock port is clk and reset port is rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ui_in  input  8  program data while programming; current PC value (from the 8-bit program counter's uo_out) while running.
REQ-005 uio_in  input  8  bit0 prog_mode, bit1 prog_wr strobe, bit2 run; bits 7:3 unused.
REQ-006 uo_out  output  8  jump target, drives the counter's parallel-load data, {3'b000, imm5}.
REQ-007 uio_out  output  8  bit3 pc_en, bit4 pc_load, bit5 pc_oe, bit6 halted, bit7 busy; bits 2:0 tied 0.
REQ-008 uio_oe  output  8  constant 8'hF8.
REQ-009 ena  input  1  ignored; it and uio_in[7:3] SHALL be folded into an unused-signal reduction.

Function
REQ-010 Storage: 16x8 program memory, 4-bit write pointer wptr, 8-bit instruction register IR, 5-bit loop counter lc, prog_wr history flop.
REQ-011 Instruction format: opcode = IR[7:5], imm5 = IR[4:0]; target = {3'b000, imm5}.
REQ-012 Opcodes: 000 NOP, 001 JMP, 010 SETLC, 011 DJNZ, 100 HALT; 101-111 SHALL execute as NOP.
REQ-013 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-014 IDLE with prog_mode=1: each rising edge of prog_wr (0 in previous cycle, 1 now) writes ui_in to mem[wptr], then wptr increments; 15 wraps to 0.
REQ-015 wptr SHALL clear to 0 in any cycle with prog_mode=0.
REQ-016 IDLE -> FETCH when run=1 and prog_mode=0; prog_mode=1 wins if both are high.
REQ-017 FETCH: IR <= mem[ui_in[3:0]]; PC bits 7:4 are ignored (aliasing); next state EXEC.
REQ-018 EXEC: drives exactly one control cycle, then goes to FETCH; HALT opcode goes to HALT instead.
REQ-019 NOP: pc_en=1 for that EXEC cycle.
REQ-020 JMP: pc_load=1 for that EXEC cycle, with uo_out = target.
REQ-021 SETLC: lc <= imm5 and pc_en=1.
REQ-022 DJNZ: lc <= lc-1, modulo 32.
REQ-023 DJNZ with (lc-1) != 0: pc_load=1, uo_out = target.
REQ-024 DJNZ with (lc-1) == 0: pc_en=1, falls through.
REQ-025 DJNZ with lc=0: wraps to 31 and jumps.
REQ-026 HALT: pc_en=pc_load=0; the block SHALL stay in HALT until run=0.
REQ-027 Timing: the counter updates on the edge ending EXEC, so the next FETCH sees the new PC; each instruction takes 2 cycles.
REQ-028 Control outputs are registered-in-state: pc_en/pc_load valid only during EXEC, never both 1.
REQ-029 uo_out holds the last target and changes only on entry to EXEC.
REQ-030 pc_oe=1 in FETCH, EXEC and HALT; 0 in IDLE.
REQ-031 busy=1 in FETCH/EXEC; halted=1 in HALT only.
REQ-032 run=0 in any non-IDLE state: next state IDLE, pc_en/pc_load forced 0 in that cycle, lc and IR retained.
REQ-033 Memory writes SHALL be ignored outside IDLE.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE, all memory words 8'h00, IR=0, lc=0, wptr=0, prog_wr history 0, uo_out=0, uio_out=0.
REQ-035 Reset mid-EXEC SHALL drop pc_en/pc_load asynchronously; operation resumes only via REQ-016.

Verification
REQ-036 Program 3 words via 3 prog_wr pulses with prog_wr held high for 2 cycles -> exactly 3 writes at addresses 0,1,2; wptr=3.
REQ-037 Program [0x00,0x00,0x20] and run with a counter model -> PC sequence 0,1,2,0,1,...; pc_en pulses on EXEC cycles; at PC 2 pc_load=1 and uo_out=0x00.
REQ-038 Program [0x43,0x00,0x00,0x61,0x80] (SETLC 3; DJNZ 1 at addr 3) -> DJNZ jumps twice then falls through to HALT at PC 4; halted=1, lc=0.
REQ-039 DJNZ with lc=0 -> lc=31 and a jump is taken.
REQ-040 Drop run during EXEC -> next cycle IDLE with pc_oe=0 and no pc_en/pc_load; prog_mode=1 and run=1 together from IDLE -> stays IDLE.
REQ-041 Assert rst_n=0 mid-program -> all outputs 0 within the same cycle and memory reads 0x00 afterwards (execution = NOP stream).

Source files
------------

// File: rtl/tt_um_8_pc_sequencer.sv
// Microsequencer that steers an external 8-bit program counter.
// Programs are written to a 16x8 memory in IDLE; instructions are executed in FETCH/EXEC pairs.
module tt_um_8_pc_sequencer (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LC_W   = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_JMP   = 3'b001;
  localparam logic [OP_W-1:0] OP_SETLC = 3'b010;
  localparam logic [OP_W-1:0] OP_DJNZ  = 3'b011;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [LC_W-1:0]     lc_q, lc_d;
  logic                prog_wr_q, prog_wr_d;
  logic [DATA_W-1:0]   uo_q, uo_d;
  logic                pc_en_q, pc_en_d;
  logic                pc_load_q, pc_load_d;
  logic                pc_oe_q, pc_oe_d;
  logic                halted_q, halted_d;
  logic                busy_q, busy_d;

  logic                prog_mode, prog_wr, run;
  logic [DATA_W-1:0]   fetched;
  logic [LC_W-1:0]     lc_dec;

  assign prog_mode = uio_in[0];
  assign prog_wr   = uio_in[1];
  assign run       = uio_in[2];
  assign fetched   = mem_q[ui_in[ADDR_W-1:0]];
  assign lc_dec    = lc_q - LC_W'(1);

  // Next-state, memory write and registered control computation
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    ir_d      = ir_q;
    lc_d      = lc_q;
    uo_d      = uo_q;
    prog_wr_d = prog_wr;
    pc_en_d   = 1'b0;
    pc_load_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (prog_mode) begin
          if (prog_wr && !prog_wr_q) begin
            mem_d[wptr_q] = ui_in;
            wptr_d        = wptr_q + ADDR_W'(1);
          end
        end else if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          // Decode here so the control strobes are flops during EXEC
          state_d = ST_EXEC;
          ir_d    = fetched;
          uo_d    = {3'b000, fetched[LC_W-1:0]};
          case (fetched[DATA_W-1 -: OP_W])
            OP_JMP:  pc_load_d = 1'b1;
            OP_DJNZ: begin
              pc_load_d = (lc_dec != '0);
              pc_en_d   = (lc_dec == '0);
            end
            OP_HALT: ;
            default: pc_en_d = 1'b1;
          endcase
        end
      end
      ST_EXEC: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          case (ir_q[DATA_W-1 -: OP_W])
            OP_SETLC: lc_d = ir_q[LC_W-1:0];
            OP_DJNZ:  lc_d = lc_dec;
            default:  ;
          endcase
          state_d = (ir_q[DATA_W-1 -: OP_W] == OP_HALT) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (!run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!prog_mode) wptr_d = '0;

    pc_oe_d  = (state_d != ST_IDLE);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      ir_q      <= '0;
      lc_q      <= '0;
      prog_wr_q <= 1'b0;
      uo_q      <= '0;
      pc_en_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_oe_q   <= 1'b0;
      halted_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      ir_q      <= ir_d;
      lc_q      <= lc_d;
      prog_wr_q <= prog_wr_d;
      uo_q      <= uo_d;
      pc_en_q   <= pc_en_d;
      pc_load_q <= pc_load_d;
      pc_oe_q   <= pc_oe_d;
      halted_q  <= halted_d;
      busy_q    <= busy_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {busy_q, halted_q, pc_oe_q, pc_load_q, pc_en_q, 3'b000};
  assign uio_oe  = 8'hF8;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:3], ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_8_pc_sequencer.sv
// Self-checking bench: drives the sequencer with an external PC model and compares
// against an instruction-level interpreter of the program memory.
module tb_tt_um_8_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       ena;

  logic       prog_mode, prog_wr, run, running;
  logic [7:0] prog_data;
  logic [7:0] pc;
  logic [7:0] img [16];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] lc0;
    logic [7:0] instr;
    logic       en;
    logic       ld;
    logic [7:0] uo;
    logic       halt;
  } vec_t;

  vec_t tbl [9];

  tt_um_8_pc_sequencer dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  assign uio_in = {5'b10101, run, prog_wr, prog_mode};
  assign ui_in  = running ? pc : prog_data;

  // External 8-bit program counter steered by the sequencer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc <= 8'h00;
    else if (uio_out[4]) pc <= uo_out;
    else if (uio_out[3]) pc <= pc + 8'h01;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; running = 1'b0; prog_mode = 1'b0; prog_wr = 1'b0;
    run = 1'b0; prog_data = 8'h00; ena = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic prog_word(input logic [7:0] d);
    prog_mode = 1'b1;
    prog_data = d;
    prog_wr   = 1'b1;
    tick;
    tick;
    prog_wr = 1'b0;
    tick;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) prog_word(img[i]);
    prog_mode = 1'b0;
    tick;
  endtask

  task automatic start_run;
    prog_mode = 1'b0;
    prog_wr   = 1'b0;
    running   = 1'b1;
    run       = 1'b1;
    tick;
  endtask

  task automatic stop_run;
    run = 1'b0;
    tick;
    check("idle_out", uio_out, 8'h00);
    running = 1'b0;
  endtask

  // Entered in FETCH; leaves in whatever state follows EXEC
  task automatic exec_instr(input logic en, input logic ld, input logic [7:0] uo);
    check("fetch_out", uio_out[7:3], 5'b10100);
    tick;
    check("exec_busy", uio_out[7], 1'b1);
    check("exec_en", uio_out[3], en);
    check("exec_load", uio_out[4], ld);
    if (ld) check("exec_uo", uo_out, uo);
    tick;
  endtask

  // Instruction-level interpreter of img[] run against the DUT, from reset (lc = 0, pc = 0)
  task automatic run_model(input int max_instr);
    int       mpc, mlc, op, imm, cnt;
    logic     en, ld;
    bit       stop;
    logic [7:0] w;
    mpc = 0; mlc = 0; cnt = 0; stop = 0;
    start_run;
    while (cnt < max_instr && !stop) begin
      check("pc_seq", pc, mpc);
      w   = img[mpc % 16];
      op  = int'(w[7:5]);
      imm = int'(w[4:0]);
      en  = 1'b0;
      ld  = 1'b0;
      case (op)
        1: ld = 1'b1;
        2: begin mlc = imm; en = 1'b1; end
        3: begin
          mlc = (mlc + 31) % 32;
          if (mlc != 0) ld = 1'b1; else en = 1'b1;
        end
        4: stop = 1;
        default: en = 1'b1;
      endcase
      exec_instr(en, ld, 8'(imm));
      if (ld)      mpc = imm;
      else if (en) mpc = (mpc + 1) % 256;
      cnt++;
    end
    if (stop) begin
      check("halt_state", uio_out[7:3], 5'b01100);
      tick;
      check("halt_hold", uio_out[7:3], 5'b01100);
    end
    check("final_pc", pc, mpc);
    stop_run;
  endtask

  initial begin
    tbl[0] = '{5'd5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};  // NOP
    tbl[1] = '{5'd3, 8'h2A, 1'b0, 1'b1, 8'h0A, 1'b0};  // JMP 10
    tbl[2] = '{5'd7, 8'h55, 1'b1, 1'b0, 8'h15, 1'b0};  // SETLC 21
    tbl[3] = '{5'd2, 8'h67, 1'b0, 1'b1, 8'h07, 1'b0};  // DJNZ taken
    tbl[4] = '{5'd1, 8'h67, 1'b1, 1'b0, 8'h07, 1'b0};  // DJNZ falls through
    tbl[5] = '{5'd0, 8'h7F, 1'b0, 1'b1, 8'h1F, 1'b0};  // DJNZ lc=0 wraps and jumps
    tbl[6] = '{5'd0, 8'hA5, 1'b1, 1'b0, 8'h05, 1'b0};  // opcode 101 as NOP
    tbl[7] = '{5'd4, 8'hE3, 1'b1, 1'b0, 8'h03, 1'b0};  // opcode 111 as NOP
    tbl[8] = '{5'd9, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};  // HALT

    do_reset;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hF8);

    // Single-instruction table, lc preloaded by a leading SETLC
    for (int t = 0; t < 9; t++) begin
      do_reset;
      img[0] = 8'h40 | {3'b000, tbl[t].lc0};
      img[1] = tbl[t].instr;
      load_prog(2);
      start_run;
      exec_instr(1'b1, 1'b0, 8'h00);
      exec_instr(tbl[t].en, tbl[t].ld, tbl[t].uo);
      check("tbl_halted", uio_out[6], tbl[t].halt);
      stop_run;
    end

    // Loop of NOP, NOP, JMP 0 with two-cycle write strobes
    do_reset;
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h20;
    load_prog(3);
    run_model(8);

    // SETLC 3 / DJNZ 1 loop ending in HALT at PC 4
    do_reset;
    img[0] = 8'h43; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h61; img[4] = 8'h80;
    load_prog(5);
    run_model(20);
    check("djnz_halt_pc", pc, 8'h04);

    // wptr clears when prog_mode drops: second session overwrites address 0
    do_reset;
    prog_word(8'h80);
    prog_word(8'h21);
    prog_mode = 1'b0;
    tick;
    prog_word(8'h00);
    prog_mode = 1'b0;
    tick;
    img[0] = 8'h00; img[1] = 8'h21;
    run_model(6);

    // run dropped during EXEC
    do_reset;
    start_run;
    tick;
    check("drop_exec_en", uio_out[3], 1'b1);
    run = 1'b0;
    tick;
    check("drop_idle", uio_out, 8'h00);
    tick;
    check("drop_stay", uio_out, 8'h00);
    running = 1'b0;

    // prog_mode wins over run in IDLE
    prog_mode = 1'b1;
    run = 1'b1;
    tick;
    tick;
    check("prog_wins", uio_out, 8'h00);
    run = 1'b0;
    prog_mode = 1'b0;
    tick;

    // Asynchronous reset mid-EXEC, then memory reads back as NOPs
    do_reset;
    img[0] = 8'h21; img[1] = 8'h21;
    load_prog(2);
    start_run;
    tick;
    check("pre_rst_load", uio_out[4], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_uo", uo_out, 8'h00);
    check("async_rst_uio", uio_out, 8'h00);
    run = 1'b0;
    running = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    run_model(5);

    // Random programs against the interpreter
    for (int r = 0; r < 8; r++) begin
      do_reset;
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      load_prog(16);
      run_model(30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
